// File: rtl/jtag_pkg.sv
// Shared TAP definitions: 1149.1 state encodings,
// next-state rule and the reserved BYPASS opcode.
package jtag_pkg;

    typedef enum logic [3:0] {
        EX2_DR = 4'h0,
        EX1_DR = 4'h1,
        SH_DR  = 4'h2,
        PAU_DR = 4'h3,
        SEL_IR = 4'h4,
        UPD_DR = 4'h5,
        CAP_DR = 4'h6,
        SEL_DR = 4'h7,
        EX2_IR = 4'h8,
        EX1_IR = 4'h9,
        SH_IR  = 4'hA,
        PAU_IR = 4'hB,
        RTI    = 4'hC,
        UPD_IR = 4'hD,
        CAP_IR = 4'hE,
        TLR    = 4'hF
    } tap_state_t;

    // All-ones opcode; sliced to the IR width at the point of use
    localparam logic [31:0] BYPASS_OP = '1;

    function automatic tap_state_t tap_next(input tap_state_t s,
                                            input logic tms);
        tap_state_t n;
        case (s)
            TLR:     n = tms ? TLR    : RTI;
            RTI:     n = tms ? SEL_DR : RTI;
            SEL_DR:  n = tms ? SEL_IR : CAP_DR;
            CAP_DR:  n = tms ? EX1_DR : SH_DR;
            SH_DR:   n = tms ? EX1_DR : SH_DR;
            EX1_DR:  n = tms ? UPD_DR : PAU_DR;
            PAU_DR:  n = tms ? EX2_DR : PAU_DR;
            EX2_DR:  n = tms ? UPD_DR : SH_DR;
            UPD_DR:  n = tms ? SEL_DR : RTI;
            SEL_IR:  n = tms ? TLR    : CAP_IR;
            CAP_IR:  n = tms ? EX1_IR : SH_IR;
            SH_IR:   n = tms ? EX1_IR : SH_IR;
            EX1_IR:  n = tms ? UPD_IR : PAU_IR;
            PAU_IR:  n = tms ? EX2_IR : PAU_IR;
            EX2_IR:  n = tms ? UPD_IR : SH_IR;
            UPD_IR:  n = tms ? SEL_DR : RTI;
            default: n = TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/tap_fsm.sv
// 16-state TAP controller with state decodes used
// by the instruction/data registers in the top.
module tap_fsm
    import jtag_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic tms,
    output logic tlr,
    output logic tlr_next,
    output logic cap_dr,
    output logic sh_dr,
    output logic upd_dr,
    output logic cap_ir,
    output logic sh_ir,
    output logic upd_ir
);

    tap_state_t state_q;
    tap_state_t state_d;

    // Next state straight from the 1149.1 transition rule
    always_comb begin
        state_d = tap_next(state_q, tms);
    end

    // State register; reset parks the controller in TLR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // State decodes; each acts on the edge leaving the state
    always_comb begin
        tlr      = (state_q == TLR);
        tlr_next = (state_d == TLR);
        cap_dr   = (state_q == CAP_DR);
        sh_dr    = (state_q == SH_DR);
        upd_dr   = (state_q == UPD_DR);
        cap_ir   = (state_q == CAP_IR);
        sh_ir    = (state_q == SH_IR);
        upd_ir   = (state_q == UPD_IR);
    end

endmodule

// File: rtl/jtag_tap_multi.sv
// TAP top: IR, IDCODE, bypass, chain decode and
// falling-edge TDO for N_CHAINS external scan chains.
module jtag_tap_multi
    import jtag_pkg::*;
#(
    parameter int              IR_W       = 4,
    parameter int              N_CHAINS   = 2,
    parameter logic [31:0]     IDCODE_VAL = 32'h0000_0001,
    parameter logic [IR_W-1:0] IDCODE_OP  = IR_W'(4'b1110)
) (
    input  logic                TCLK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    output logic                TDO_EN,
    input  logic [N_CHAINS-1:0] chain_tdo,
    output logic [N_CHAINS-1:0] dr_capture,
    output logic [N_CHAINS-1:0] dr_shift,
    output logic [N_CHAINS-1:0] dr_update,
    output logic [IR_W-1:0]     ir_q,
    output logic                tlr
);

    logic tlr_next;
    logic cap_dr;
    logic sh_dr;
    logic upd_dr;
    logic cap_ir;
    logic sh_ir;
    logic upd_ir;

    tap_fsm u_fsm (
        .clk      (TCLK),
        .rst      (TRST),
        .tms      (TMS),
        .tlr      (tlr),
        .tlr_next (tlr_next),
        .cap_dr   (cap_dr),
        .sh_dr    (sh_dr),
        .upd_dr   (upd_dr),
        .cap_ir   (cap_ir),
        .sh_ir    (sh_ir),
        .upd_ir   (upd_ir)
    );

    logic [IR_W-1:0]     ir_d;
    logic [IR_W-1:0]     ir_sr_q;
    logic [IR_W-1:0]     ir_sr_d;
    logic [31:0]         id_sr_q;
    logic [31:0]         id_sr_d;
    logic                byp_q;
    logic                byp_d;
    logic                tdo_q;
    logic                tdo_d;
    logic                tdo_en_q;
    logic                tdo_en_d;
    logic [N_CHAINS-1:0] chain_oh;
    logic                sel_id;
    logic                sel_byp;
    logic                dr_tdo;

    // Instruction decode: chain one-hot, IDCODE, or bypass fallback
    always_comb begin
        chain_oh = '0;
        for (int k = 0; k < N_CHAINS; k++) begin
            if (ir_q == IR_W'(k)) begin
                chain_oh[k] = 1'b1;
            end
        end
        sel_id  = (ir_q == IDCODE_OP);
        sel_byp = (ir_q == BYPASS_OP[IR_W-1:0]) ||
                  (!(|chain_oh) && !sel_id);
    end

    // Chain strobes gated by the selected chain
    always_comb begin
        dr_capture = {N_CHAINS{cap_dr}} & chain_oh;
        dr_shift   = {N_CHAINS{sh_dr}}  & chain_oh;
        dr_update  = {N_CHAINS{upd_dr}} & chain_oh;
    end

    // IR shifter and instruction latch; entering TLR forces IDCODE
    always_comb begin
        ir_sr_d = ir_sr_q;
        if (cap_ir) begin
            ir_sr_d = IR_W'(2'b01);
        end else if (sh_ir) begin
            ir_sr_d = {TDI, ir_sr_q[IR_W-1:1]};
        end
        ir_d = ir_q;
        if (tlr_next) begin
            ir_d = IDCODE_OP;
        end else if (upd_ir) begin
            ir_d = ir_sr_q;
        end
    end

    // IDCODE and bypass registers move only while selected
    always_comb begin
        id_sr_d = id_sr_q;
        if (sel_id && cap_dr) begin
            id_sr_d = IDCODE_VAL;
        end else if (sel_id && sh_dr) begin
            id_sr_d = {TDI, id_sr_q[31:1]};
        end
        byp_d = byp_q;
        if (sel_byp && cap_dr) begin
            byp_d = 1'b0;
        end else if (sel_byp && sh_dr) begin
            byp_d = TDI;
        end
    end

    // Rising-edge register state
    always_ff @(posedge TCLK or posedge TRST) begin
        if (TRST) begin
            ir_q    <= IDCODE_OP;
            ir_sr_q <= '0;
            id_sr_q <= IDCODE_VAL;
            byp_q   <= 1'b0;
        end else begin
            ir_q    <= ir_d;
            ir_sr_q <= ir_sr_d;
            id_sr_q <= id_sr_d;
            byp_q   <= byp_d;
        end
    end

    // TDO source select; value holds outside the shift states
    always_comb begin
        if (|chain_oh) begin
            dr_tdo = |(chain_oh & chain_tdo);
        end else if (sel_id) begin
            dr_tdo = id_sr_q[0];
        end else begin
            dr_tdo = byp_q;
        end
        tdo_d = tdo_q;
        if (sh_ir) begin
            tdo_d = ir_sr_q[0];
        end else if (sh_dr) begin
            tdo_d = dr_tdo;
        end
        tdo_en_d = sh_ir | sh_dr;
    end

    // Falling-edge output stage
    always_ff @(negedge TCLK or posedge TRST) begin
        if (TRST) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    assign TDO    = tdo_q;
    assign TDO_EN = tdo_en_q;

endmodule

// File: tb/tb_jtag_tap_multi.sv
// Randomised bench for jtag_tap_multi: transaction-level
// expectations for IDCODE, bypass and chain scans.
module tb_jtag_tap_multi;

    localparam int          IR_W = 4;
    localparam int          NC   = 2;
    localparam logic [31:0] IDV  = 32'h4BA0_0477;
    localparam logic [3:0]  IDOP = 4'b1110;

    logic          TCLK = 1'b0;
    logic          TRST = 1'b1;
    logic          TMS  = 1'b0;
    logic          TDI  = 1'b0;
    logic          TDO;
    logic          TDO_EN;
    logic [NC-1:0] chain_tdo;
    logic [NC-1:0] dr_capture;
    logic [NC-1:0] dr_shift;
    logic [NC-1:0] dr_update;
    logic [3:0]    ir_q;
    logic          tlr;

    jtag_tap_multi #(
        .IR_W       (IR_W),
        .N_CHAINS   (NC),
        .IDCODE_VAL (IDV),
        .IDCODE_OP  (IDOP)
    ) dut (
        .TCLK       (TCLK),
        .TRST       (TRST),
        .TMS        (TMS),
        .TDI        (TDI),
        .TDO        (TDO),
        .TDO_EN     (TDO_EN),
        .chain_tdo  (chain_tdo),
        .dr_capture (dr_capture),
        .dr_shift   (dr_shift),
        .dr_update  (dr_update),
        .ir_q       (ir_q),
        .tlr        (tlr)
    );

    always #5 TCLK = ~TCLK;

    // External 8-bit scan chains hanging off the chain ports
    logic [7:0] chain_reg [NC] = '{8'h00, 8'h00};
    logic [7:0] chain_cap [NC] = '{8'h00, 8'h00};

    always @(posedge TCLK) begin
        for (int k = 0; k < NC; k++) begin
            if (dr_capture[k])
                chain_reg[k] <= chain_cap[k];
            else if (dr_shift[k])
                chain_reg[k] <= {TDI, chain_reg[k][7:1]};
        end
    end

    always_comb begin
        for (int k = 0; k < NC; k++) chain_tdo[k] = chain_reg[k][0];
    end

    int   n_chk = 0;
    int   n_bad = 0;
    int   cap_n [NC];
    int   sh_n  [NC];
    int   upd_n [NC];
    logic smp_tdo;
    logic smp_en;
    logic ex1_en;
    logic ex1_tdo;
    bit   en_ok;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] msk(input int n);
        return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    endfunction

    function automatic int strb_sum();
        int s = 0;
        for (int k = 0; k < NC; k++) s += cap_n[k] + sh_n[k] + upd_n[k];
        return s;
    endfunction

    task automatic clr();
        for (int k = 0; k < NC; k++) begin
            cap_n[k] = 0;
            sh_n[k]  = 0;
            upd_n[k] = 0;
        end
    endtask

    // One TCK: sample outputs of the current state, then drive the edge
    task automatic tick(input logic tms, input logic tdi);
        @(negedge TCLK);
        #1;
        smp_tdo = TDO;
        smp_en  = TDO_EN;
        for (int k = 0; k < NC; k++) begin
            cap_n[k] += int'(dr_capture[k]);
            sh_n[k]  += int'(dr_shift[k]);
            upd_n[k] += int'(dr_update[k]);
        end
        TMS = tms;
        TDI = tdi;
        @(posedge TCLK);
        #1;
    endtask

    task automatic go_rti();
        repeat (5) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    // From RTI: scan an instruction, return what came out of TDO
    task automatic load_ir(input logic [3:0] op, output logic [3:0] iro);
        clr();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < IR_W; i++) begin
            tick(i == IR_W - 1, op[i]);
            iro[i] = smp_tdo;
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        chk("ir_strobes", 64'(strb_sum()), 64'd0);
        chk("ir_q", 64'(ir_q), 64'(op));
    endtask

    // From RTI: scan n DR bits, optional pause after bit pz
    task automatic scan_dr(input int n, input logic [63:0] din,
                           input int pz, output logic [63:0] dout);
        logic lst;
        logic pse;
        clr();
        en_ok = 1'b1;
        dout  = '0;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            lst = (i == n - 1);
            pse = (i == pz) && !lst;
            tick(lst | pse, din[i]);
            dout[i] = smp_tdo;
            if (!smp_en) en_ok = 1'b0;
            if (pse) begin
                tick(1'b0, 1'b0);
                tick(1'b0, 1'b0);
                chk("pause_en", 64'(smp_en), 64'd0);
                tick(1'b0, 1'b0);
                tick(1'b0, 1'b0);
                tick(1'b1, 1'b0);
                tick(1'b0, 1'b0);
            end
        end
        tick(1'b1, 1'b0);
        ex1_en  = smp_en;
        ex1_tdo = smp_tdo;
        tick(1'b0, 1'b0);
    endtask

    task automatic idcode_case(input int n, input int pz);
        logic [63:0] din;
        logic [63:0] dout;
        logic [63:0] exp;
        go_rti();
        chk("id_ir", 64'(ir_q), 64'(IDOP));
        din = {$urandom, $urandom};
        scan_dr(n, din, pz, dout);
        exp = ((din << 32) | 64'(IDV)) & msk(n);
        chk("id_data", dout, exp);
        chk("id_strobes", 64'(strb_sum()), 64'd0);
        chk("id_en", 64'({en_ok, ex1_en}), 64'b10);
    endtask

    task automatic bypass_case(input logic [3:0] op, input int n,
                               input int pz);
        logic [3:0]  iro;
        logic [63:0] din;
        logic [63:0] dout;
        logic [63:0] exp;
        load_ir(op, iro);
        chk("byp_ircap", 64'(iro), 64'b0001);
        din = {$urandom, $urandom};
        scan_dr(n, din, pz, dout);
        exp = (din << 1) & msk(n);
        chk("byp_data", dout, exp);
        chk("byp_strobes", 64'(strb_sum()), 64'd0);
        chk("byp_en", 64'({en_ok, ex1_en}), 64'b10);
        chk("byp_hold", 64'(ex1_tdo), 64'(exp[n-1]));
    endtask

    task automatic chain_case(input int k, input logic [7:0] din,
                              input int pz);
        logic [3:0]  iro;
        logic [63:0] dout;
        logic [7:0]  oth;
        int          o;
        o = 1 - k;
        chain_cap[k] = 8'($urandom);
        load_ir(4'(k), iro);
        chk("ch_ircap", 64'(iro), 64'b0001);
        oth = chain_reg[o];
        scan_dr(8, 64'(din), pz, dout);
        chk("ch_tdo", dout, 64'(chain_cap[k]));
        chk("ch_shifted", 64'(chain_reg[k]), 64'(din));
        chk("ch_other", 64'(chain_reg[o]), 64'(oth));
        chk("ch_counts", 64'({cap_n[k][7:0], sh_n[k][7:0], upd_n[k][7:0]}),
            64'h01_08_01);
        chk("ch_other_cnt", 64'(cap_n[o] + sh_n[o] + upd_n[o]), 64'd0);
        chk("ch_en", 64'({en_ok, ex1_en}), 64'b10);
    endtask

    initial begin
        logic [3:0] iro;
        int         n;
        int         kind;
        logic [3:0] op;

        #12;
        chk("rst_tlr", 64'(tlr), 64'd1);
        chk("rst_ir", 64'(ir_q), 64'(IDOP));
        chk("rst_tdo", 64'({TDO, TDO_EN}), 64'd0);
        chk("rst_strobes", 64'({dr_capture, dr_shift, dr_update}), 64'd0);
        @(negedge TCLK);
        #1 TRST = 1'b0;

        // IDCODE from reset: TMS 0,1,0,0 then 32 bits
        tick(1'b0, 1'b0);
        begin
            logic [63:0] dout;
            scan_dr(32, {$urandom, $urandom}, -1, dout);
            chk("id_reset", dout, 64'(IDV));
            chk("id_reset_strb", 64'(strb_sum()), 64'd0);
        end

        // TRST in the middle of a chain shift
        load_ir(4'd0, iro);
        clr();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        #2 TRST = 1'b1;
        #1;
        chk("trst_tlr", 64'(tlr), 64'd1);
        chk("trst_ir", 64'(ir_q), 64'(IDOP));
        chk("trst_out", 64'({TDO, TDO_EN}), 64'd0);
        chk("trst_strb", 64'({dr_capture, dr_shift, dr_update}), 64'd0);
        repeat (2) @(posedge TCLK);
        #1 chk("trst_upd", 64'(dr_update), 64'd0);
        @(negedge TCLK);
        #1 TRST = 1'b0;
        chk("trst_updcnt", 64'(upd_n[0] + upd_n[1]), 64'd0);
        tick(1'b0, 1'b0);

        // TRST in the middle of an IR shift leaves ir_q untouched
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        #2 TRST = 1'b1;
        #3 TRST = 1'b0;
        tick(1'b0, 1'b0);
        chk("trst_ir_abort", 64'(ir_q), 64'(IDOP));

        chain_case(1, 8'hA5, -1);
        bypass_case(4'b1111, 10, -1);
        bypass_case(4'b1010, 10, -1);
        chain_case(0, 8'h3C, 3);

        // Random wander, then five TMS=1 edges must land in TLR
        for (int w = 0; w < 16; w++) begin
            n = $urandom_range(0, 14);
            for (int j = 0; j < n; j++)
                tick(1'($urandom), 1'($urandom));
            repeat (5) tick(1'b1, 1'b0);
            chk("five_tlr", 64'(tlr), 64'd1);
            chk("five_ir", 64'(ir_q), 64'(IDOP));
        end
        tick(1'b0, 1'b0);

        for (int r = 0; r < 24; r++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                n = $urandom_range(32, 48);
                idcode_case(n, ($urandom % 2) ? $urandom_range(0, n - 2) : -1);
            end else if (kind == 1) begin
                op = 4'($urandom_range(2, 15));
                if (op == IDOP) op = 4'hF;
                n = $urandom_range(2, 40);
                bypass_case(op, n, ($urandom % 2) ? $urandom_range(0, n - 2) : -1);
            end else begin
                chain_case($urandom_range(0, NC - 1), 8'($urandom),
                           ($urandom % 2) ? $urandom_range(0, 6) : -1);
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/jtag_tap_multi.md
# jtag_tap_multi

Parametrised JTAG test-access port: an IEEE 1149.1 16-state TAP controller, an IR_W-bit instruction register, a bypass register, a 32-bit IDCODE register and a TDO multiplexer. It drives capture, shift and update strobes for N_CHAINS external scan chains (boundary, internal, etc.). It replaces per-design hand-wired TAP/IR/bypass/mux tops, and each circuit's scan chains hang off its chain ports.

## Interface
- IR_W, default 4: instruction register width, at least 2.
- N_CHAINS, default 2: number of external data-register chains, 1 to 2^IR_W−2.
- IDCODE_VAL, default 32'h0000_0001: device ID. Bit 0 must be 1.
- IDCODE_OP, default 4'b1110: opcode selecting IDCODE. Must be ≥ N_CHAINS and not all-ones.
- TCLK  in  1  test clock, the only clock; all state changes on the rising edge except TDO/TDO_EN.
- TRST  in  1  reset, asynchronous, active-high.
- TMS  in  1  mode select, sampled on the rising TCLK edge.
- TDI  in  1  serial data in, sampled on the rising edge.
- TDO  out  1  serial data out, changes on the falling edge.
- TDO_EN  out  1  high while shifting, changes on the falling edge.
- chain_tdo  in  N_CHAINS  serial output of each chain.
- dr_capture  out  N_CHAINS  one-hot or zero; high in CAPTURE_DR for the selected chain.
- dr_shift  out  N_CHAINS  high in SHIFT_DR for the selected chain.
- dr_update  out  N_CHAINS  high in UPDATE_DR for the selected chain.
- ir_q  out  IR_W  current instruction.
- tlr  out  1  high while in TEST_LOGIC_RESET.

## Operation
- FSM states use the standard 1149.1 states and TMS transitions: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR.
- Five consecutive TMS=1 edges reach TLR from any state.
- Instruction decode:
  - opcode k < N_CHAINS selects chain k.
  - opcode == IDCODE_OP selects IDCODE.
  - all-ones, and every other opcode, selects BYPASS.
- IR shift register:
  - CAP_IR loads {0…0,2'b01}.
  - SH_IR shifts right, TDI into the MSB; TDO is the LSB.
  - The UPD_IR edge copies the shift register to ir_q.
  - While in TLR, ir_q is held at IDCODE_OP.
- IDCODE register (32 bits): CAP_DR loads IDCODE_VAL; SH_DR shifts right, TDI into bit 31; TDO is bit 0.
- Bypass register (1 bit): CAP_DR loads 0; SH_DR loads TDI.
- Chain strobes are combinational decodes of the current state ANDed with the selected-chain one-hot. They act on the rising edge that leaves the state.
- Outside DR states, or when IDCODE/BYPASS is selected, all three strobe vectors are 0.
- Internal IDCODE and bypass registers move only when selected.
- TDO mux: in SH_IR it outputs the IR LSB; in SH_DR it outputs the selected source (chain_tdo[k], IDCODE bit 0 or bypass).
- TDO is registered on the falling edge. It holds its last value when TDO_EN=0.

## Timing
- Reset values while TRST=1:
  - state TLR, ir_q=IDCODE_OP
  - IR shift register 0, IDCODE shift register IDCODE_VAL, bypass 0
  - TDO=0, TDO_EN=0, tlr=1, all strobes 0
- TRST asserted mid-shift aborts the operation immediately. ir_q is not updated from the partial shift.
- TDO_EN=1 on the falling edge in SH_DR/SH_IR; it drops on the first falling edge after leaving them.
- Latency TDI→TDO through bypass is one TCLK. The first bit after CAP_DR is the captured value (bypass 0, IDCODE bit0=1).
- A new instruction affects decode starting in the state after UPD_IR, i.e. RTI or SEL_DR.
- EX1/PAU/EX2 states hold all registers; shifting resumes intact from PAU.

## Structure
- Package jtag_pkg:
  - tap_state_t enum, 4-bit, standard 1149.1 encodings (TLR=4'hF, RTI=4'hC, SH_DR=4'h2, SH_IR=4'hA, …)
  - next-state function
  - constant BYPASS_OP = all-ones
- Sub-module tap_fsm: state register and strobe/state decode (tlr, cap/sh/upd for DR and IR).
- The top holds the IR, IDCODE, bypass, decode and TDO mux.

## Test plan
- Pulse TRST mid-SH_DR → state TLR, ir_q=4'b1110, TDO_EN=0, no dr_update pulse.
- From reset, TMS 0,1,0,0 then shift 32 bits → TDO yields 32'h0000_0001 LSB-first; dr_* stay 0.
- Load IR 4'b0001 and scan 8 bits of 8'hA5 into chain 1 → dr_capture[1] one cycle, dr_shift[1] high exactly 8 cycles, dr_update[1] one cycle, chain 0 strobes 0, TDO follows chain_tdo[1].
- Load IR 4'b1111 and shift 10 bits → TDO equals TDI delayed one TCLK, first bit 0; no chain strobes.
- Shift IR with 4'b1010 (unused) → BYPASS behaviour; IR TDO during shift begins with 1,0 (captured 01).
- From every state, five TMS=1 edges → TLR and ir_q=IDCODE_OP; pause mid-DR 3 cycles and resume → shifted data contiguous.
